// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline definitions: NOP encoding, fetch-state enum,
// decode opcodes and a saturating increment used by the perf counters.
package dlx_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0015;

   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQZ = 6'h04;
   localparam logic [5:0] OP_BNEZ = 6'h05;
   localparam logic [5:0] OP_LW   = 6'h23;

   typedef enum logic [1:0] {
      FS_RUN   = 2'd0,
      FS_WAIT  = 2'd1,
      FS_REDIR = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns PC, pending redirect target and the RUN/WAIT/REDIR FSM.
// Exposes redirect_o only when IF_ID_FETCH_PERF_EN is defined.
module fetch_pc_ctrl
   import dlx_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   input  logic        fetch_ready,
   output logic [31:0] pc_o,
   output logic        deliver_o
`ifdef IF_ID_FETCH_PERF_EN
   ,
   output logic        redirect_o
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pend_q, pend_d;
   logic [31:0]  tgt;
   logic         deliver;
   logic         redirect;

   assign tgt = {branch_target_in[31:2], 2'b00};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pend_d   = pend_q;
      deliver  = 1'b0;
      redirect = 1'b0;
      if (!stall_in) begin
         unique case (state_q)
            // Delay slot still owed: decode holds a bubble, so branches here are spurious.
            FS_REDIR: begin
               if (fetch_ready) begin
                  deliver = 1'b1;
                  pc_d    = pend_q;
                  state_d = FS_RUN;
               end
            end
            default: begin
               if (branch_taken_in) begin
                  redirect = 1'b1;
                  if (fetch_ready) begin
                     pc_d    = tgt;
                     deliver = DELAY_SLOT;
                     state_d = FS_RUN;
                  end else if (DELAY_SLOT) begin
                     pend_d  = tgt;
                     state_d = FS_REDIR;
                  end else begin
                     pc_d    = tgt;
                     state_d = FS_WAIT;
                  end
               end else if (fetch_ready) begin
                  deliver = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = FS_RUN;
               end else begin
                  state_d = FS_WAIT;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FS_RUN;
         pc_q    <= RESET_PC;
         pend_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

   assign pc_o      = pc_q;
   assign deliver_o = deliver;
`ifdef IF_ID_FETCH_PERF_EN
   assign redirect_o = redirect;
`else
   logic unused_redirect;
   assign unused_redirect = redirect;
`endif

endmodule

// File: rtl/if_id_fetch_stage.sv
// DLX instruction fetch plus IF/ID register with stall, kill and delayed-branch redirect.
// Optional perf counters when IF_ID_FETCH_PERF_EN is defined.
module if_id_fetch_stage
   import dlx_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_in,
   input  logic        kill_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [0:31] imem_rdata,
   input  logic        imem_ready,
   output logic [0:31] instr_out,
   output logic [31:0] pc_plus_four_out,
   output logic        should_be_killed_out,
   output logic        valid_out
`ifdef IF_ID_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles,
   output logic [31:0] perf_redirects
`endif
);

   logic [31:0] pc;
   logic        deliver;
   logic [0:31] instr_q, instr_d;
   logic [31:0] ppf_q, ppf_d;
   logic        kill_q, kill_d;
   logic        valid_q, valid_d;
`ifdef IF_ID_FETCH_PERF_EN
   logic        redirect;
`endif

   fetch_pc_ctrl #(
      .RESET_PC   (RESET_PC),
      .DELAY_SLOT (DELAY_SLOT)
   ) u_pc_ctrl (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_in         (stall_in),
      .branch_taken_in  (branch_taken_in),
      .branch_target_in (branch_target_in),
      .fetch_ready      (imem_ready),
      .pc_o             (pc),
      .deliver_o        (deliver)
`ifdef IF_ID_FETCH_PERF_EN
      ,
      .redirect_o       (redirect)
`endif
   );

   assign imem_req  = rst_n;
   assign imem_addr = pc;

   // Every unstalled edge reloads IF/ID, either with the fetched word or a bubble.
   always_comb begin
      instr_d = instr_q;
      ppf_d   = ppf_q;
      kill_d  = kill_q;
      valid_d = valid_q;
      if (!stall_in) begin
         kill_d  = kill_in;
         valid_d = deliver;
         if (deliver) begin
            instr_d = imem_rdata;
            ppf_d   = pc + 32'd4;
         end else begin
            instr_d = NOP_INSTR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q <= NOP_INSTR;
         ppf_q   <= RESET_PC + 32'd4;
         kill_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         ppf_q   <= ppf_d;
         kill_q  <= kill_d;
         valid_q <= valid_d;
      end
   end

   assign instr_out            = instr_q;
   assign pc_plus_four_out     = ppf_q;
   assign should_be_killed_out = kill_q;
   assign valid_out            = valid_q;

`ifdef IF_ID_FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] bubbles_q, bubbles_d;
   logic [31:0] redirects_q, redirects_d;

   always_comb begin
      fetched_d   = fetched_q;
      bubbles_d   = bubbles_q;
      redirects_d = redirects_q;
      if (!stall_in) begin
         if (deliver) fetched_d = sat_inc(fetched_q);
         else         bubbles_d = sat_inc(bubbles_q);
         if (redirect) redirects_d = sat_inc(redirects_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetched_q   <= 32'h0;
         bubbles_q   <= 32'h0;
         redirects_q <= 32'h0;
      end else begin
         fetched_q   <= fetched_d;
         bubbles_q   <= bubbles_d;
         redirects_q <= redirects_d;
      end
   end

   assign perf_fetched   = fetched_q;
   assign perf_bubbles   = bubbles_q;
   assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: two instances (DELAY_SLOT=0 and 1) share stimulus;
// directed scenarios check fixed values, a random run checks an instruction-level model.
module tb_if_id_fetch_stage;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0015;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_in = 1'b0;
   logic        kill_in = 1'b0;
   logic        br_in = 1'b0;
   logic [31:0] tgt_in = 32'h0;
   logic        ready = 1'b0;

   logic        req [2];
   logic [31:0] addr [2];
   logic [0:31] rdata [2];
   logic [0:31] instr [2];
   logic [31:0] ppf [2];
   logic        kill_o [2];
   logic        valid [2];

   int chk = 0;
   int err = 0;

   // Behavioural model state, one per delay-slot flavour
   logic [31:0] m_pc [2];
   logic        m_owed [2];
   logic [31:0] m_tgt [2];
   logic [31:0] m_instr [2];
   logic [31:0] m_ppf [2];
   logic        m_kill [2];
   logic        m_valid [2];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   assign rdata[0] = mem_word(addr[0]);
   assign rdata[1] = mem_word(addr[1]);

   if_id_fetch_stage #(.RESET_PC(RPC), .DELAY_SLOT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .kill_in(kill_in),
      .branch_taken_in(br_in), .branch_target_in(tgt_in),
      .imem_req(req[0]), .imem_addr(addr[0]), .imem_rdata(rdata[0]), .imem_ready(ready),
      .instr_out(instr[0]), .pc_plus_four_out(ppf[0]),
      .should_be_killed_out(kill_o[0]), .valid_out(valid[0]));

   if_id_fetch_stage #(.RESET_PC(RPC), .DELAY_SLOT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .kill_in(kill_in),
      .branch_taken_in(br_in), .branch_target_in(tgt_in),
      .imem_req(req[1]), .imem_addr(addr[1]), .imem_rdata(rdata[1]), .imem_ready(ready),
      .instr_out(instr[1]), .pc_plus_four_out(ppf[1]),
      .should_be_killed_out(kill_o[1]), .valid_out(valid[1]));

   // Instruction-level model: what decode should see after this edge.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         logic give;
         logic [31:0] word;
         logic [31:0] at;
         give = 1'b0;
         at   = m_pc[d];
         word = mem_word(m_pc[d]);
         if (!rst_n) begin
            m_pc[d] = RPC; m_owed[d] = 1'b0; m_tgt[d] = 32'h0;
            m_instr[d] = NOP; m_ppf[d] = RPC + 32'd4; m_kill[d] = 1'b0; m_valid[d] = 1'b0;
         end else if (!stall_in) begin
            if (m_owed[d]) begin
               if (ready) begin give = 1'b1; m_pc[d] = m_tgt[d]; m_owed[d] = 1'b0; end
            end else if (br_in) begin
               if (ready) begin give = (d == 1); m_pc[d] = tgt_in & ~32'd3; end
               else if (d == 1) begin m_owed[d] = 1'b1; m_tgt[d] = tgt_in & ~32'd3; end
               else m_pc[d] = tgt_in & ~32'd3;
            end else if (ready) begin
               give = 1'b1; m_pc[d] = m_pc[d] + 32'd4;
            end
            m_kill[d]  = kill_in;
            m_valid[d] = give;
            m_instr[d] = give ? word : NOP;
            if (give) m_ppf[d] = at + 32'd4;
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic b, input logic k,
                       input logic rd, input logic [31:0] t);
      rst_n = r; stall_in = s; br_in = b; kill_in = k; ready = rd; tgt_in = t;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h800);
      for (int d = 0; d < 2; d++) begin
         chk++; if (addr[d] !== RPC) begin err++; $display("FAIL reset_addr d%0d got %h exp %h", d, addr[d], RPC); end
         chk++; if (valid[d] !== 1'b0) begin err++; $display("FAIL reset_valid d%0d got %b exp 0", d, valid[d]); end
         chk++; if (instr[d] !== NOP) begin err++; $display("FAIL reset_instr d%0d got %h exp %h", d, instr[d], NOP); end
         chk++; if (kill_o[d] !== 1'b0) begin err++; $display("FAIL reset_kill d%0d got %b exp 0", d, kill_o[d]); end
         chk++; if (ppf[d] !== RPC + 32'd4) begin err++; $display("FAIL reset_ppf d%0d got %h exp %h", d, ppf[d], RPC + 32'd4); end
         chk++; if (req[d] !== 1'b0) begin err++; $display("FAIL reset_req d%0d got %b exp 0", d, req[d]); end
      end
      rst_n = 1'b1;
      #1;
      chk++; if (req[1] !== 1'b1) begin err++; $display("FAIL req_after_reset got %b exp 1", req[1]); end
   endtask

   task automatic test_straight_line();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a;
         a = RPC + 32'(4 * i);
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
         chk++; if (instr[1] !== mem_word(a)) begin err++; $display("FAIL straight_instr i%0d got %h exp %h", i, instr[1], mem_word(a)); end
         chk++; if (ppf[1] !== a + 32'd4) begin err++; $display("FAIL straight_ppf i%0d got %h exp %h", i, ppf[1], a + 32'd4); end
         chk++; if (valid[1] !== 1'b1) begin err++; $display("FAIL straight_valid i%0d got %b exp 1", i, valid[1]); end
         chk++; if (addr[1] !== a + 32'd4) begin err++; $display("FAIL straight_addr i%0d got %h exp %h", i, addr[1], a + 32'd4); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h400);
         chk++; if (instr[1] !== mem_word(32'h104)) begin err++; $display("FAIL stall_instr i%0d got %h exp %h", i, instr[1], mem_word(32'h104)); end
         chk++; if (addr[1] !== 32'h108) begin err++; $display("FAIL stall_addr i%0d got %h exp 108", i, addr[1]); end
         chk++; if (kill_o[1] !== 1'b0) begin err++; $display("FAIL stall_kill i%0d got %b exp 0", i, kill_o[1]); end
         chk++; if (ppf[0] !== 32'h108) begin err++; $display("FAIL stall_ppf i%0d got %h exp 108", i, ppf[0]); end
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk++; if (instr[1] !== mem_word(32'h108)) begin err++; $display("FAIL stall_resume_instr got %h exp %h", instr[1], mem_word(32'h108)); end
      chk++; if (addr[1] !== 32'h10C) begin err++; $display("FAIL stall_resume_addr got %h exp 10c", addr[1]); end
   endtask

   task automatic test_branch();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h203);
      chk++; if (instr[1] !== mem_word(32'h108)) begin err++; $display("FAIL br_slot_instr got %h exp %h", instr[1], mem_word(32'h108)); end
      chk++; if (valid[1] !== 1'b1) begin err++; $display("FAIL br_slot_valid got %b exp 1", valid[1]); end
      chk++; if (ppf[1] !== 32'h10C) begin err++; $display("FAIL br_slot_ppf got %h exp 10c", ppf[1]); end
      chk++; if (instr[0] !== NOP) begin err++; $display("FAIL br_ds0_instr got %h exp %h", instr[0], NOP); end
      chk++; if (valid[0] !== 1'b0) begin err++; $display("FAIL br_ds0_valid got %b exp 0", valid[0]); end
      for (int d = 0; d < 2; d++) begin
         chk++; if (addr[d] !== 32'h200) begin err++; $display("FAIL br_target d%0d got %h exp 200", d, addr[d]); end
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      for (int d = 0; d < 2; d++) begin
         chk++; if (instr[d] !== mem_word(32'h200)) begin err++; $display("FAIL br_after d%0d got %h exp %h", d, instr[d], mem_word(32'h200)); end
      end
   endtask

   task automatic test_branch_miss();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
      chk++; if (addr[0] !== 32'h300) begin err++; $display("FAIL miss_ds0_addr got %h exp 300", addr[0]); end
      for (int i = 0; i < 3; i++) begin
         if (i == 1) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         if (i == 2) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500);
         chk++; if (valid[1] !== 1'b0 || instr[1] !== NOP) begin err++; $display("FAIL miss_bubble i%0d got v=%b %h exp v=0 %h", i, valid[1], instr[1], NOP); end
         chk++; if (addr[1] !== 32'h104) begin err++; $display("FAIL miss_hold_addr i%0d got %h exp 104", i, addr[1]); end
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk++; if (instr[1] !== mem_word(32'h104) || valid[1] !== 1'b1) begin err++; $display("FAIL miss_slot got v=%b %h exp v=1 %h", valid[1], instr[1], mem_word(32'h104)); end
      chk++; if (ppf[1] !== 32'h108) begin err++; $display("FAIL miss_slot_ppf got %h exp 108", ppf[1]); end
      chk++; if (addr[1] !== 32'h300) begin err++; $display("FAIL miss_target got %h exp 300", addr[1]); end
      chk++; if (addr[0] !== 32'h504) begin err++; $display("FAIL miss_ds0_rebranch got %h exp 504", addr[0]); end
   endtask

   task automatic test_kill_wrap();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      chk++; if (kill_o[1] !== 1'b1 || valid[1] !== 1'b1) begin err++; $display("FAIL kill_set got k=%b v=%b exp k=1 v=1", kill_o[1], valid[1]); end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk++; if (kill_o[1] !== 1'b0) begin err++; $display("FAIL kill_clear got %b exp 0", kill_o[1]); end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk++; if (kill_o[1] !== 1'b1 || valid[1] !== 1'b0) begin err++; $display("FAIL kill_bubble got k=%b v=%b exp k=1 v=0", kill_o[1], valid[1]); end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      chk++; if (kill_o[1] !== 1'b1) begin err++; $display("FAIL kill_hold_stall got %b exp 1", kill_o[1]); end
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      for (int d = 0; d < 2; d++) begin
         chk++; if (addr[d] !== 32'h0) begin err++; $display("FAIL wrap_addr d%0d got %h exp 0", d, addr[d]); end
         chk++; if (ppf[d] !== 32'h0) begin err++; $display("FAIL wrap_ppf d%0d got %h exp 0", d, ppf[d]); end
         chk++; if (instr[d] !== mem_word(32'hFFFF_FFFC)) begin err++; $display("FAIL wrap_instr d%0d got %h exp %h", d, instr[d], mem_word(32'hFFFF_FFFC)); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic r, s, b, k, rd;
         logic [31:0] t;
         r  = ($urandom_range(0, 99) >= 2);
         s  = ($urandom_range(0, 99) < 15);
         b  = ($urandom_range(0, 99) < 20);
         k  = ($urandom_range(0, 99) < 15);
         rd = ($urandom_range(0, 99) < 70);
         t  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         step(r, s, b, k, rd, t);
         for (int d = 0; d < 2; d++) begin
            chk++;
            if (addr[d] !== m_pc[d] || instr[d] !== m_instr[d] || valid[d] !== m_valid[d] ||
                kill_o[d] !== m_kill[d] || (m_valid[d] && ppf[d] !== m_ppf[d])) begin
               err++;
               $display("FAIL rand c%0d d%0d got a=%h i=%h v=%b k=%b p=%h exp a=%h i=%h v=%b k=%b p=%h",
                        i, d, addr[d], instr[d], valid[d], kill_o[d], ppf[d],
                        m_pc[d], m_instr[d], m_valid[d], m_kill[d], m_ppf[d]);
            end
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_pc[d] = RPC; m_owed[d] = 1'b0; m_tgt[d] = 32'h0; m_instr[d] = NOP;
         m_ppf[d] = RPC + 32'd4; m_kill[d] = 1'b0; m_valid[d] = 1'b0;
      end
      #2;
      test_reset();
      test_straight_line();
      test_stall();
      test_branch();
      test_branch_miss();
      test_kill_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage DLX pipeline; sits directly upstream of the decode/control stage.
- Owns the PC and issues fetches to instruction memory.
- Delivers `instr`, `pc_plus_four` and `should_be_killed` to decode.
- Applies decode's stall, kill and taken-branch/jump redirect, including DLX branch-delay-slot semantics across memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = instruction after a taken branch/jump executes; 0 = it is squashed to NOP.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- stall_in  in  1  decode load-use stall; hold PC and IF/ID
- kill_in  in  1  mark the next instruction delivered to decode as killed
- branch_taken_in  in  1  decode resolved a taken branch/jump this cycle
- branch_target_in  in  32  redirect target, [31:0]
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, [31:0], equal to PC
- imem_rdata  in  32  fetched instruction, big-endian [0:31]
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr
- instr_out  out  32  IF/ID instruction, [0:31]
- pc_plus_four_out  out  32  IF/ID PC+4 of instr_out
- should_be_killed_out  out  1  instr_out must not write regs/mem
- valid_out  out  1  instr_out is a real fetched instruction (0 = bubble)

Behaviour:
- Reset (rst_n=0 at posedge):
  - PC=RESET_PC; state=RUN; pending target=0.
  - instr_out=NOP (32'h0000_0015); pc_plus_four_out=RESET_PC+4.
  - should_be_killed_out=0; valid_out=0.
  - Reset overrides everything, mid-wait or mid-redirect included.
- imem_req=1 whenever rst_n=1; imem_addr=PC combinationally.
- Fetch completes when imem_req & imem_ready at the clock edge. Zero-latency memory yields 1 instruction/cycle.
- Per-edge priority, highest first: reset > stall_in > branch_taken_in > normal.
- stall_in=1:
  - PC, IF/ID, state and pending register all hold.
  - branch_taken_in and kill_in are ignored; decode re-presents them after the stall.
  - A fetch completing during the stall is discarded and re-issued.
- State RUN:
  - ready=1, no branch: IF/ID<=rdata, pc_plus_four_out<=PC+4, valid_out=1, PC<=PC+4.
  - ready=0, no branch: PC holds; IF/ID<=NOP, valid_out=0; go WAIT.
  - branch with ready=1: PC<=target. IF/ID<=rdata (the delay slot) if DELAY_SLOT=1; otherwise NOP with valid_out=0.
  - branch with ready=0, DELAY_SLOT=1: latch target into pending; IF/ID<=NOP; go REDIR.
  - branch with ready=0, DELAY_SLOT=0: PC<=target; IF/ID<=NOP; go WAIT. The abandoned fetch is not re-requested.
- State WAIT (same as RUN, entered after a miss):
  - ready=1 returns to RUN with the normal load.
  - A branch in WAIT is handled as in RUN.
- State REDIR:
  - Hold PC at the delay-slot address; IF/ID<=NOP until ready.
  - On ready: IF/ID<=delay slot, valid_out=1, PC<=pending, go RUN.
  - A further branch_taken_in in REDIR is ignored: decode is holding a bubble, so no legal source exists.
- kill_in=1 (no stall): the instruction loaded into IF/ID at this edge gets should_be_killed_out=1. A bubble loaded then also gets 1.
- should_be_killed_out is 0 on every other load and holds with IF/ID on stall.
- PC arithmetic is 32-bit modulo: PC=32'hFFFF_FFFC + 4 wraps to 0, and pc_plus_four_out wraps the same way.
- branch_target_in bits [1:0] are forced to 0 when loaded.

Optional Feature:
- Macro: IF_ID_FETCH_PERF_EN.
- When defined, three outputs are added:
  - perf_fetched [31:0]: completed fetches delivered with valid_out=1.
  - perf_bubbles [31:0]: cycles loading a bubble, excluding stall cycles.
  - perf_redirects [31:0]: accepted redirects.
- Counters reset to 0 and saturate at all-ones.
- When undefined, the outputs and counters do not exist and all other behaviour is identical.

Decomposition:
- Shared package dlx_pipe_pkg holds:
  - NOP_INSTR=32'h0000_0015 and the fetch-state enum (RUN, WAIT, REDIR).
  - Opcode localparams already used by decode (J=6'h02, JAL=6'h03, BEQZ=6'h04, BNEZ=6'h05, LW=6'h23).
- One natural sub-module, fetch_pc_ctrl: the state machine plus PC/pending registers.
- The top level holds the IF/ID register and the optional counters.

Test Plan:
- Reset with RESET_PC=32'h100 → imem_addr=32'h100, valid_out=0, instr_out=32'h0000_0015. First ready → instr_out=rdata, pc_plus_four_out=32'h104.
- Straight line, ready tied 1, at 0x100/0x104/0x108 → one instruction per cycle; pc_plus_four_out 0x104, 0x108, 0x10C.
- stall_in for 2 cycles with instr at 0x104 in IF/ID → instr_out and imem_addr frozen; resumes at 0x108.
- branch_taken_in with target 0x200 at PC=0x108 → delay slot (0x108) delivered, next imem_addr=0x200. With DELAY_SLOT=0 the slot becomes NOP, valid_out=0.
- Branch to 0x300 while ready=0 for 3 cycles (DELAY_SLOT=1) → 3 bubbles, delay slot delivered, then imem_addr=0x300.
- kill_in with lw in decode → next instr_out has should_be_killed_out=1. PC=0xFFFF_FFFC → wraps to imem_addr=0.
